// File: rtl/shfr_pkg.sv
// ---------------------------------------------------------------------------
// shfr_pkg -- shared definitions for the sequential right shifter.
//   state_t    : FSM state encoding (IDLE, SHIFT, DONE)
//   cnt_width(): width of a counter that must hold 0..bus_size inclusive
// ---------------------------------------------------------------------------
package shfr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Counter must reach bus_size itself, hence the +1.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/shfr_seq_if.sv
// ---------------------------------------------------------------------------
// shfr_seq_if -- request/result bundle for shfr_seq.
//   start  : request, only looked at while busy=0
//   A, B   : data to shift and shift-amount selector
//   busy   : high while an operation is in progress
//   done   : one-cycle pulse, result valid in that cycle
//   result : shifted data, held until the next accepted start
// master drives the request side, slave is the shifter.
// ---------------------------------------------------------------------------
interface shfr_seq_if #(
   parameter int bus_size = 8
);
   logic                start;
   logic [bus_size-1:0] A;
   logic [bus_size-1:0] B;
   logic                busy;
   logic                done;
   logic [bus_size-1:0] result;

   modport master (output start, A, B, input  busy, done, result);
   modport slave  (input  start, A, B, output busy, done, result);
endinterface

// File: rtl/shfr_seq_lso_enc.sv
// ---------------------------------------------------------------------------
// lso_enc -- combinational least-significant-one encoder.
//   i_b    : selector word
//   o_n    : (index of lowest set bit of i_b) + 1, or 0 when i_b == 0
//   o_zero : high when i_b == 0
// ---------------------------------------------------------------------------
module lso_enc
   import shfr_pkg::*;
#(
   parameter int bus_size = 8,
   localparam int CW      = cnt_width(bus_size)
) (
   input  logic [bus_size-1:0] i_b,
   output logic [CW-1:0]       o_n,
   output logic                o_zero
);

   // Scan from MSB down so the lowest set bit is the last one written.
   always_comb begin
      o_n = '0;
      for (int i = bus_size - 1; i >= 0; i--) begin
         if (i_b[i]) o_n = CW'(i + 1);
      end
   end

   assign o_zero = ~|i_b;

endmodule

// File: rtl/shfr_seq.sv
// ---------------------------------------------------------------------------
// shfr_seq -- sequential right shifter, one bit per clock.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, aborts any operation
//   bus : shfr_seq_if.slave (start, A, B in; busy, done, result out)
// Shift amount is derived from the lowest set bit of B (B==0 -> no shift).
// Build option: define SHFR_ARITH_EN for an arithmetic (sign-filling) shift;
// left undefined the MSB is filled with 0 (logical shift).
// ---------------------------------------------------------------------------
module shfr_seq
   import shfr_pkg::*;
#(
   parameter int bus_size = 8
) (
   input  logic       clk,
   input  logic       rst,
   shfr_seq_if.slave  bus
);

   localparam int CW = cnt_width(bus_size);

   state_t              r_state;
   logic [bus_size-1:0] r_data_q;
   logic [CW-1:0]       r_cnt_q;
   logic                r_busy;
   logic                r_done;

   logic [CW-1:0]       w_n;
   logic                w_zero;
   logic                w_fill;

   lso_enc #(.bus_size(bus_size)) u_lso_enc (
      .i_b    (bus.B),
      .o_n    (w_n),
      .o_zero (w_zero)
   );

`ifdef SHFR_ARITH_EN
   assign w_fill = r_data_q[bus_size-1];
`else
   assign w_fill = 1'b0;
`endif

   // busy/done are registered alongside the state so they track it exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_data_q <= '0;
         r_cnt_q  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_data_q <= bus.A;
                  r_cnt_q  <= w_n;
                  r_busy   <= 1'b1;
                  if (w_zero) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               r_data_q <= {w_fill, r_data_q[bus_size-1:1]};
               r_cnt_q  <= r_cnt_q - CW'(1);
               if (r_cnt_q == CW'(1)) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               // start is deliberately not looked at here.
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_data_q;

endmodule
